// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, funct3 codes and state type for the RV32M multiply/divide unit
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - core-side operand/result bundle for the multiply/divide unit
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic [31:0]     inst;
    logic [XLEN-1:0] DataA;
    logic [XLEN-1:0] DataB;
    logic [XLEN-1:0] result;
    logic            done;
    logic            stall;

    modport master (output start, inst, DataA, DataB, input result, done, stall);
    modport slave  (input start, inst, DataA, DataB, output result, done, stall);

endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one combinational shift-add or restoring-subtract step
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] rem_diff;
    logic            rem_ge;

    // Multiply: {hi,lo} holds product-high and the remaining multiplier bits.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        rem_shift = {hi, lo[XLEN-1]};
        rem_diff  = {1'b0, rem_shift} - {2'b00, opnd};
        rem_ge    = ~rem_diff[XLEN+1];
        if (is_div) begin
            hi_nxt = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], rem_ge};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // The remainder stays below the divisor, so these top bits never carry information.
    wire unused_bits = ^{rem_diff[XLEN], rem_shift[XLEN]};

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with stall/done handshake
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);

    state_t            state, state_nxt;
    logic [2:0]        f3_q;
    logic              sign_a_q, sign_b_q;
    logic [XLEN-1:0]   opnd_q, hi_q, lo_q, result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   hi_nxt, lo_nxt;

    logic [2:0]        f3_in;
    logic              a_signed, b_signed, sa_in, sb_in;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   abs_a, abs_b, special_res;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   fix_res;

    assign f3_in = bus.inst[14:12];
    wire unused_inst = ^{bus.inst[31:15], bus.inst[11:0]};

    muldiv_iter u_iter (
        .is_div (f3_q[2]),
        .hi     (hi_q),
        .lo     (lo_q),
        .opnd   (opnd_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Decode the incoming operands: signedness, magnitudes and the one-cycle special cases.
    always_comb begin
        a_signed = (f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
                   (f3_in == F3_DIV)  || (f3_in == F3_REM);
        b_signed = (f3_in == F3_MULH) || (f3_in == F3_DIV) || (f3_in == F3_REM);
        sa_in    = a_signed && bus.DataA[XLEN-1];
        sb_in    = b_signed && bus.DataB[XLEN-1];
        abs_a    = sa_in ? -bus.DataA : bus.DataA;
        abs_b    = sb_in ? -bus.DataB : bus.DataB;
        div_zero = f3_in[2] && (bus.DataB == '0);
        div_ovf  = f3_in[2] && b_signed && (bus.DataA == SIGN_MIN) && (bus.DataB == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = f3_in[1] ? bus.DataA : '1;
        end else begin
            special_res = f3_in[1] ? '0 : SIGN_MIN;
        end
    end

    // Sign correction and result selection applied in FIX.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
        case (f3_q)
            F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
            default:                      fix_res = sign_a_q ? -hi_q : hi_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = special ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(ITERS - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        f3_q     <= f3_in;
                        sign_a_q <= sa_in;
                        sign_b_q <= sb_in;
                        opnd_q   <= f3_in[2] ? abs_b : abs_a;
                        hi_q     <= '0;
                        lo_q     <= f3_in[2] ? abs_a : abs_b;
                        cnt_q    <= '0;
                        if (special) result_q <= special_res;
                    end
                end
                CALC: begin
                    hi_q  <= hi_nxt;
                    lo_q  <= lo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = (state == DONE);
    // Held low during reset so an aborted instruction releases the core at once.
    assign bus.stall  = ~rst & (((state == IDLE) & bus.start) | (state == CALC) | (state == FIX));

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking scoreboard bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    muldiv_if ifc();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            F3_MUL:    return a * b;
            F3_MULH:   return 32'((sa * sb) >> 32);
            F3_MULHSU: return 32'((sa * ub) >> 32);
            F3_MULHU:  return 32'((ua * ub) >> 32);
            F3_DIV:    return (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'($signed(a) / $signed(b));
            F3_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            F3_REM:    return (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'($signed(a) % $signed(b));
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 34;
    endfunction

    // Issues one instruction and waits (bounded) for done; start is dropped in the DONE cycle.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stall_cycles,
                         output logic stall_at_done, output bit timed_out);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.inst  = mk_inst(f3);
        ifc.DataA = a;
        ifc.DataB = b;
        lat = 0;
        stall_cycles = 0;
        stall_at_done = 1'b1;
        timed_out = 1'b1;
        res = '0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (ifc.done) begin
                res = ifc.result;
                stall_at_done = ifc.stall;
                timed_out = 1'b0;
                ifc.start = 1'b0;
                break;
            end
            if (ifc.stall) stall_cycles++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ifc.start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ifc.result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected %h", ifc.result, 32'd0); end
        checks++; if (ifc.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", ifc.done); end
        checks++; if (ifc.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", ifc.stall); end
    endtask

    task automatic test_mul;
        logic [31:0] res, exp;
        int lat, stl;
        logic sd;
        bit to;
        exp_q.push_back(32'hFFFFFFEB);
        do_op(F3_MUL, 32'd7, 32'hFFFFFFFD, res, lat, stl, sd, to);
        exp = exp_q.pop_front();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL mul_7x-3: got %h expected %h timeout %0d", res, exp, to); end
        checks++; if (lat != 34) begin failures++; $display("FAIL mul_latency: got %0d expected 34", lat); end
        checks++; if (stl != 34) begin failures++; $display("FAIL mul_stall_cycles: got %0d expected 34", stl); end
        checks++; if (sd !== 1'b0) begin failures++; $display("FAIL mul_stall_in_done: got %b expected 0", sd); end
    endtask

    task automatic test_mul_high;
        logic [2:0]  f3s [3] = '{F3_MULH, F3_MULHU, F3_MULHSU};
        logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps[3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] res, exp;
        int lat, stl;
        logic sd;
        bit to;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            do_op(f3s[i], as[i], bs[i], res, lat, stl, sd, to);
            exp = exp_q.pop_front();
            checks++; if (to || res !== exp) begin failures++; $display("FAIL mul_high f3=%0d a=%h b=%h: got %h expected %h", f3s[i], as[i], bs[i], res, exp); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  f3s [4] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
        logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd2, 32'd7};
        logic [31:0] exps[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2};
        logic [31:0] res, exp;
        int lat, stl;
        logic sd;
        bit to;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            do_op(f3s[i], as[i], bs[i], res, lat, stl, sd, to);
            exp = exp_q.pop_front();
            checks++; if (to || res !== exp) begin failures++; $display("FAIL div f3=%0d a=%h b=%h: got %h expected %h", f3s[i], as[i], bs[i], res, exp); end
            checks++; if (lat != 34) begin failures++; $display("FAIL div_latency f3=%0d: got %0d expected 34", f3s[i], lat); end
        end
    endtask

    task automatic test_div_special;
        logic [2:0]  f3s [4] = '{F3_DIV, F3_REM, F3_DIV, F3_REM};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] res, exp;
        int lat, stl;
        logic sd;
        bit to;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            do_op(f3s[i], as[i], bs[i], res, lat, stl, sd, to);
            exp = exp_q.pop_front();
            checks++; if (to || res !== exp) begin failures++; $display("FAIL div_special f3=%0d a=%h b=%h: got %h expected %h", f3s[i], as[i], bs[i], res, exp); end
            checks++; if (lat != 1) begin failures++; $display("FAIL div_special_latency f3=%0d: got %0d expected 1", f3s[i], lat); end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] res, exp;
        int lat, stl;
        logic sd;
        bit to;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.inst  = mk_inst(F3_DIV);
        ifc.DataA = 32'd1000;
        ifc.DataB = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (ifc.stall !== 1'b1) begin failures++; $display("FAIL abort_pre_stall: got %b expected 1", ifc.stall); end
        checks++; if (ifc.result !== 32'd2) begin failures++; $display("FAIL abort_pre_result: got %h expected %h", ifc.result, 32'd2); end
        rst = 1'b1;
        ifc.start = 1'b0;
        #1;
        checks++; if (ifc.done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", ifc.done); end
        checks++; if (ifc.result !== 32'd0) begin failures++; $display("FAIL abort_result: got %h expected 0", ifc.result); end
        checks++; if (ifc.stall !== 1'b0) begin failures++; $display("FAIL abort_stall: got %b expected 0", ifc.stall); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'd12);
        do_op(F3_MUL, 32'd3, 32'd4, res, lat, stl, sd, to);
        exp = exp_q.pop_front();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL abort_then_mul: got %h expected %h", res, exp); end
        checks++; if (lat != 34) begin failures++; $display("FAIL abort_then_mul_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int lat, stl, elat;
        logic sd;
        bit to;
        for (int i = 0; i < 14; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (f3[2] && (i % 3 == 0)) b = 32'($urandom_range(1, 15));
            if (i % 5 == 4) b = 32'd0;
            if (i % 7 == 6) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            elat = ref_latency(f3, a, b);
            exp_q.push_back(ref_model(f3, a, b));
            do_op(f3, a, b, res, lat, stl, sd, to);
            exp = exp_q.pop_front();
            checks++; if (to || res !== exp) begin failures++; $display("FAIL random f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, exp); end
            checks++; if (lat != elat) begin failures++; $display("FAIL random_latency f3=%0d: got %0d expected %0d", f3, lat, elat); end
        end
    endtask

    task automatic test_back_to_back;
        int edges = 0;
        int dones = 0;
        int first_edge = -1;
        int gap = -1;
        logic [31:0] exp;
        exp_q.push_back(32'd42);
        exp_q.push_back(32'd45);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.inst  = mk_inst(F3_MUL);
        ifc.DataA = 32'd6;
        ifc.DataB = 32'd7;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ifc.done) begin
                dones++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_extra_done: got result %h expected no done", ifc.result);
                end else begin
                    exp = exp_q.pop_front();
                    if (ifc.result !== exp) begin failures++; $display("FAIL b2b_result %0d: got %h expected %h", dones, ifc.result, exp); end
                end
                if (dones == 1) begin
                    first_edge = edges;
                    ifc.DataA = 32'd5;
                    ifc.DataB = 32'd9;
                end else if (dones == 2) begin
                    gap = edges - first_edge;
                    ifc.start = 1'b0;
                end
            end
        end
        ifc.start = 1'b0;
        checks++; if (dones != 2) begin failures++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
        checks++; if (gap != 35) begin failures++; $display("FAIL b2b_gap: got %0d expected 35", gap); end
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.inst  = '0;
        ifc.DataA = '0;
        ifc.DataB = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_reset_abort();
        test_div_special();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
